ready_lobby_ctrl: RTL and testbench
===================================

// Module: ready_lobby_ctrl
// PURPOSE
//  Sequences the pre-game "ready" overlay and the game enable. Latches each player's
//  ready press, runs a frame-counted countdown once both are ready, then raises game_en.
//  Returns to the lobby after game over. Drives start/game_en of the ready-overlay
//  drawer. Sits between the input/UART layer and the VGA draw chain.
// PARAMETERS
//  STEP_FRAMES   60   frame ticks per countdown step
//  CNT_STEPS     3    countdown steps shown (count value CNT_STEPS..1)
//  BLINK_FRAMES  30   frame ticks per half-period of the "waiting" blink
//  OVER_FRAMES   120  frame ticks held in game-over before returning to lobby
// PORTS
//  clk        in   1  pixel clock
//  rst        in   1  synchronous reset, active-high
//  vsync      in   1  VGA vsync from timing chain; rising edge = frame tick
//  menu_en    in   1  level: main menu finished, lobby may open
//  p1_btn     in   1  one-cycle pulse, player 1 ready (synchronised, debounced)
//  p2_btn     in   1  one-cycle pulse, player 2 ready
//  cancel     in   1  one-cycle pulse, abort countdown
//  game_over  in   1  one-cycle pulse from game logic
//  start      out  1  ready overlay visible (WAIT, COUNTDOWN)
//  game_en    out  1  gameplay running (PLAY only)
//  p1_rdy     out  1  player 1 ready latched
//  p2_rdy     out  1  player 2 ready latched
//  blink      out  1  toggles every BLINK_FRAMES ticks in WAIT; 0 elsewhere
//  count      out  2  countdown digit (CNT_STEPS..1) in COUNTDOWN; 0 elsewhere
//  over       out  1  game-over banner active (OVER only)
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, every output 0, counters 0, vsync edge reg 0.
//  - Frame tick: tick = vsync & ~vsync_q (vsync_q registered); one clk wide.
//  - FSM states: IDLE, WAIT, COUNTDOWN, PLAY, OVER. Outputs change the cycle after the cause.
//  - IDLE: menu_en=1 -> WAIT; frame counter and p1_rdy/p2_rdy cleared.
//  - WAIT: p1_btn sets p1_rdy, p2_btn sets p2_rdy (sticky; repeat presses no effect).
//    Both pulses in same cycle set both. When p1_rdy & p2_rdy both 1 -> COUNTDOWN,
//    count<=CNT_STEPS, frame counter<=0. blink toggles when frame counter reaches
//    BLINK_FRAMES-1 on a tick, then counter wraps to 0.
//  - COUNTDOWN: frame counter increments per tick; at STEP_FRAMES-1 on a tick it
//    wraps to 0 and count decrements; tick with count==1 at wrap -> PLAY, count<=0.
//    cancel -> WAIT, p1_rdy/p2_rdy cleared, count<=0; cancel wins over a
//    simultaneous expiry tick.
//  - PLAY: game_en=1, start=0. game_over -> OVER, frame counter<=0. Buttons ignored.
//  - OVER: over=1, game_en=0; after OVER_FRAMES ticks -> WAIT with readiness cleared.
//  - menu_en=0 in any state except PLAY -> IDLE (same as reset, sync).
//  - Frame counter width = clog2 of max(STEP_FRAMES,BLINK_FRAMES,OVER_FRAMES); never
//    exceeds its terminal value; counter cleared on every state change.
//  - Button/cancel/game_over pulses outside their owning state are ignored, not queued.
//  - rst mid-operation (any state) returns to IDLE next cycle, outputs 0.
// TESTING
//  (use STEP_FRAMES=2, CNT_STEPS=3, BLINK_FRAMES=2, OVER_FRAMES=3, short vsync period)
//  - rst, menu_en=1 -> start=1, game_en=0, p1_rdy=p2_rdy=0, blink toggles every 2 ticks.
//  - p1_btn then p2_btn 5 cycles later -> p1_rdy, p2_rdy set; count=3, then 2,1 every
//    2 ticks; 2 ticks after count=1 -> game_en=1, start=0, count=0.
//  - p1_btn & p2_btn same cycle -> both rdy set, COUNTDOWN next cycle.
//  - cancel at count=2 coincident with step tick -> WAIT, rdy cleared, count=0.
//  - game_over in PLAY -> over=1, game_en=0; after 3 ticks -> start=1, over=0.
//  - rst asserted in COUNTDOWN -> all outputs 0 next cycle; menu_en drop in WAIT -> IDLE.

Source files
------------

// File: rtl/ready_lobby_if.sv
`default_nettype none
// ============================================================================
//  Module   : ready_lobby_if
//  Purpose  : Bundles the lobby controller's frame/input strobes and its
//             overlay/game-enable outputs. The master modport drives the
//             inputs (input/UART layer); the slave modport is the controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface ready_lobby_if;
  // Inputs to the controller
  logic       vsync;
  logic       menu_en;
  logic       p1_btn;
  logic       p2_btn;
  logic       cancel;
  logic       game_over;
  // Outputs from the controller
  logic       start;
  logic       game_en;
  logic       p1_rdy;
  logic       p2_rdy;
  logic       blink;
  logic [1:0] count;
  logic       over;

  modport master (
    output vsync, menu_en, p1_btn, p2_btn, cancel, game_over,
    input  start, game_en, p1_rdy, p2_rdy, blink, count, over
  );

  modport slave (
    input  vsync, menu_en, p1_btn, p2_btn, cancel, game_over,
    output start, game_en, p1_rdy, p2_rdy, blink, count, over
  );
endinterface
`default_nettype wire

// File: rtl/ready_lobby_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ready_lobby_ctrl
//  Purpose  : Pre-game lobby sequencer. Latches player ready presses, runs a
//             frame-counted countdown once both players are ready, enables
//             gameplay, and shows a timed game-over banner before reopening
//             the lobby. Every output is registered.
//  Revision : 1.0 - initial release
// ============================================================================
module ready_lobby_ctrl #(
  parameter int STEP_FRAMES  = 60,
  parameter int CNT_STEPS    = 3,
  parameter int BLINK_FRAMES = 30,
  parameter int OVER_FRAMES  = 120
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ready_lobby_if.slave       bus
);

  // Frame counter must hold the largest terminal value of any phase.
  localparam int MAX_SB     = (STEP_FRAMES > BLINK_FRAMES) ? STEP_FRAMES : BLINK_FRAMES;
  localparam int MAX_FRAMES = (MAX_SB > OVER_FRAMES) ? MAX_SB : OVER_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_FRAMES - 1);
  localparam logic [1:0]       COUNT_INIT = 2'(CNT_STEPS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT      = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_PLAY      = 3'd3,
    S_OVER      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic             p1_rdy_q, p1_rdy_d;
  logic             p2_rdy_q, p2_rdy_d;
  logic             blink_q, blink_d;
  logic [1:0]       count_q, count_d;
  logic             vsync_q;
  logic             start_q;
  logic             game_en_q;
  logic             over_q;
  logic             frame_tick;

  // One-cycle strobe on each rising edge of vsync.
  assign frame_tick = bus.vsync & ~vsync_q;

  // Next-state and counter logic for the lobby sequence.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    p1_rdy_d = p1_rdy_q;
    p2_rdy_d = p2_rdy_q;
    blink_d  = blink_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        frame_d  = '0;
        p1_rdy_d = 1'b0;
        p2_rdy_d = 1'b0;
        blink_d  = 1'b0;
        count_d  = 2'd0;
        if (bus.menu_en) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.p1_btn) p1_rdy_d = 1'b1;
        if (bus.p2_btn) p2_rdy_d = 1'b1;
        if (frame_tick) begin
          if (frame_q == BLINK_LAST) begin
            frame_d = '0;
            blink_d = ~blink_q;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
        // Uses the freshly latched readiness so a press is acted on at once.
        if (p1_rdy_d && p2_rdy_d) begin
          state_d = S_COUNTDOWN;
          count_d = COUNT_INIT;
          frame_d = '0;
        end
      end

      S_COUNTDOWN: begin
        // Abort takes priority over a coincident step expiry.
        if (bus.cancel) begin
          state_d  = S_WAIT;
          p1_rdy_d = 1'b0;
          p2_rdy_d = 1'b0;
          count_d  = 2'd0;
          frame_d  = '0;
        end else if (frame_tick) begin
          if (frame_q == STEP_LAST) begin
            frame_d = '0;
            if (count_q == 2'd1) begin
              state_d = S_PLAY;
              count_d = 2'd0;
            end else begin
              count_d = count_q - 2'd1;
            end
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end

      S_PLAY: begin
        if (bus.game_over) begin
          state_d = S_OVER;
          frame_d = '0;
        end
      end

      S_OVER: begin
        if (frame_tick) begin
          if (frame_q == OVER_LAST) begin
            state_d  = S_WAIT;
            frame_d  = '0;
            p1_rdy_d = 1'b0;
            p2_rdy_d = 1'b0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        frame_d = '0;
      end
    endcase

    // Losing the menu outside gameplay behaves like a soft reset.
    if (!bus.menu_en && (state_q != S_PLAY)) begin
      state_d  = S_IDLE;
      frame_d  = '0;
      p1_rdy_d = 1'b0;
      p2_rdy_d = 1'b0;
      count_d  = 2'd0;
    end

    // Blink is only meaningful while waiting for players.
    if (state_d != S_WAIT) begin
      blink_d = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      p1_rdy_q  <= 1'b0;
      p2_rdy_q  <= 1'b0;
      blink_q   <= 1'b0;
      count_q   <= 2'd0;
      vsync_q   <= 1'b0;
      start_q   <= 1'b0;
      game_en_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      p1_rdy_q  <= p1_rdy_d;
      p2_rdy_q  <= p2_rdy_d;
      blink_q   <= blink_d;
      count_q   <= count_d;
      vsync_q   <= bus.vsync;
      start_q   <= (state_d == S_WAIT) || (state_d == S_COUNTDOWN);
      game_en_q <= (state_d == S_PLAY);
      over_q    <= (state_d == S_OVER);
    end
  end

  assign bus.start   = start_q;
  assign bus.game_en = game_en_q;
  assign bus.p1_rdy  = p1_rdy_q;
  assign bus.p2_rdy  = p2_rdy_q;
  assign bus.blink   = blink_q;
  assign bus.count   = count_q;
  assign bus.over    = over_q;

endmodule
`default_nettype wire

// File: tb/tb_ready_lobby_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ready_lobby_ctrl
//  Purpose  : Directed self-checking bench for ready_lobby_ctrl with short
//             frame parameters. Outputs are packed as
//             {start, game_en, p1_rdy, p2_rdy, blink, count[1:0], over}.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ready_lobby_ctrl;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  ready_lobby_if bus ();

  ready_lobby_ctrl #(
    .STEP_FRAMES  (2),
    .CNT_STEPS    (3),
    .BLINK_FRAMES (2),
    .OVER_FRAMES  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] outs();
    return {bus.start, bus.game_en, bus.p1_rdy, bus.p2_rdy,
            bus.blink, bus.count, bus.over};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // One frame tick: vsync high for a cycle, then low for a cycle.
  task automatic frame();
    bus.vsync = 1'b1;
    cyc();
    bus.vsync = 1'b0;
    cyc();
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = outs();
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.vsync     = 1'b0;
    bus.menu_en   = 1'b1;
    bus.p1_btn    = 1'b0;
    bus.p2_btn    = 1'b0;
    bus.cancel    = 1'b0;
    bus.game_over = 1'b0;

    // Reset state
    cycles(2);
    chk("reset", 8'h00);
    rst = 1'b0;
    cyc();
    chk("wait_entry", 8'h80);

    // Blink toggles every 2 ticks
    frame();
    chk("blink_tick1", 8'h80);
    frame();
    chk("blink_on", 8'h88);
    frame();
    frame();
    chk("blink_off", 8'h80);

    // p1 then p2 five cycles later, then full countdown
    bus.p1_btn = 1'b1;
    cyc();
    bus.p1_btn = 1'b0;
    chk("p1_latched", 8'hA0);
    cycles(4);
    bus.p2_btn = 1'b1;
    cyc();
    bus.p2_btn = 1'b0;
    chk("countdown_3", 8'hB6);
    frame();
    chk("countdown_3_hold", 8'hB6);
    frame();
    chk("countdown_2", 8'hB4);
    frame();
    frame();
    chk("countdown_1", 8'hB2);
    frame();
    chk("countdown_1_hold", 8'hB2);
    frame();
    chk("play", 8'h70);

    // menu_en drop is ignored during gameplay
    bus.menu_en = 1'b0;
    cyc();
    bus.menu_en = 1'b1;
    chk("play_menu_drop", 8'h70);

    // Game over banner for 3 ticks, then lobby reopens
    bus.game_over = 1'b1;
    cyc();
    bus.game_over = 1'b0;
    chk("over", 8'h31);
    frame();
    frame();
    chk("over_hold", 8'h31);
    frame();
    chk("over_to_wait", 8'h80);

    // Simultaneous presses
    bus.p1_btn = 1'b1;
    bus.p2_btn = 1'b1;
    cyc();
    bus.p1_btn = 1'b0;
    bus.p2_btn = 1'b0;
    chk("both_same_cycle", 8'hB6);

    // Cancel coincident with the step tick at count 2
    frame();
    frame();
    chk("cancel_setup_2", 8'hB4);
    frame();
    bus.vsync  = 1'b1;
    bus.cancel = 1'b1;
    cyc();
    bus.vsync  = 1'b0;
    bus.cancel = 1'b0;
    chk("cancel_wins", 8'h80);
    cyc();

    // Reset in countdown
    bus.p1_btn = 1'b1;
    bus.p2_btn = 1'b1;
    cyc();
    bus.p1_btn = 1'b0;
    bus.p2_btn = 1'b0;
    chk("countdown_again", 8'hB6);
    rst = 1'b1;
    cyc();
    chk("rst_in_countdown", 8'h00);
    rst = 1'b0;
    cyc();
    chk("wait_after_rst", 8'h80);

    // menu_en drop in WAIT returns to IDLE; buttons there are ignored
    bus.p1_btn = 1'b1;
    cyc();
    bus.p1_btn = 1'b0;
    chk("p1_before_drop", 8'hA0);
    bus.menu_en = 1'b0;
    cyc();
    chk("menu_drop_wait", 8'h00);
    bus.p1_btn = 1'b1;
    cyc();
    bus.p1_btn = 1'b0;
    chk("idle_btn_ignored", 8'h00);

    // Cancel and game_over outside their states are ignored
    bus.menu_en = 1'b1;
    cyc();
    bus.cancel    = 1'b1;
    bus.game_over = 1'b1;
    cyc();
    bus.cancel    = 1'b0;
    bus.game_over = 1'b0;
    chk("wait_stray_pulses", 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
